// File: rtl/window_read_sequencer.sv
// Walks the CNN register bank as sliding convolution windows, issuing one-hot read selects
// to the bank mux and handing each sample to the MAC stage over a valid/ready handshake.
module window_read_sequencer #(
  parameter int DATANUM = 15,
  parameter int KSIZE   = 3
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_start,
  input  logic                       i_clr,
  input  logic                       i_rd_ready,
  output logic                       o_rd_valid,
  output logic [DATANUM-1:0]         o_rd_sel,
  output logic [$clog2(DATANUM)-1:0] o_win_idx,
  output logic [$clog2(KSIZE)-1:0]   o_tap_idx,
  output logic                       o_last_tap,
  output logic                       o_last_win,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam int NWIN = DATANUM - KSIZE + 1;
  localparam int WW   = $clog2(DATANUM);
  localparam int TW   = $clog2(KSIZE);

  localparam logic [WW-1:0]      WIN_LAST   = WW'(NWIN - 1);
  localparam logic [TW-1:0]      TAP_LAST   = TW'(KSIZE - 1);
  localparam logic [DATANUM-1:0] SEL_SAMPLE0 = {1'b1, {(DATANUM-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic                 r_rdValid;
  logic [DATANUM-1:0]   r_rdSel;
  logic [DATANUM-1:0]   r_winBase;
  logic [WW-1:0]        r_winIdx;
  logic [TW-1:0]        r_tapIdx;
  logic                 r_lastTap;
  logic                 r_lastWin;
  logic                 r_done;

  logic                 w_handshake;
  logic [DATANUM-1:0]   w_selRot;
  logic [DATANUM-1:0]   w_baseRot;

  assign w_handshake = r_rdValid & i_rd_ready;
  assign w_selRot    = {r_rdSel[DATANUM-2:0], r_rdSel[DATANUM-1]};
  assign w_baseRot   = {r_winBase[DATANUM-2:0], r_winBase[DATANUM-1]};

  // Window base tracks the first sample of the current window so a window step never
  // has to rewind rd_sel by KSIZE-1 positions.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_state   <= S_IDLE;
      r_rdValid <= 1'b0;
      r_rdSel   <= '0;
      r_winBase <= '0;
      r_winIdx  <= '0;
      r_tapIdx  <= '0;
      r_lastTap <= 1'b0;
      r_lastWin <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_state   <= S_READ;
            r_rdValid <= 1'b1;
            r_rdSel   <= SEL_SAMPLE0;
            r_winBase <= SEL_SAMPLE0;
            r_winIdx  <= '0;
            r_tapIdx  <= '0;
            r_lastTap <= 1'b0;
            r_lastWin <= (NWIN == 1);
          end
        end
        S_READ: begin
          if (w_handshake) begin
            if (r_tapIdx != TAP_LAST) begin
              r_tapIdx  <= r_tapIdx + 1'b1;
              r_rdSel   <= w_selRot;
              r_lastTap <= ((r_tapIdx + 1'b1) == TAP_LAST);
            end else if (r_winIdx != WIN_LAST) begin
              r_tapIdx  <= '0;
              r_winIdx  <= r_winIdx + 1'b1;
              r_winBase <= w_baseRot;
              r_rdSel   <= w_baseRot;
              r_lastTap <= 1'b0;
              r_lastWin <= ((r_winIdx + 1'b1) == WIN_LAST);
            end else begin
              r_state   <= S_DONE;
              r_rdValid <= 1'b0;
              r_rdSel   <= '0;
              r_winBase <= '0;
              r_winIdx  <= '0;
              r_tapIdx  <= '0;
              r_lastTap <= 1'b0;
              r_lastWin <= 1'b0;
              r_done    <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state   <= S_IDLE;
          r_rdValid <= 1'b0;
          r_rdSel   <= '0;
          r_done    <= 1'b0;
        end
      endcase
    end
  end

  assign o_rd_valid = r_rdValid;
  assign o_rd_sel   = r_rdSel;
  assign o_win_idx  = r_winIdx;
  assign o_tap_idx  = r_tapIdx;
  assign o_last_tap = r_lastTap;
  assign o_last_win = r_lastWin;
  assign o_busy     = (r_state != S_IDLE);
  assign o_done     = r_done;

endmodule

// File: tb/tb_window_read_sequencer.sv
// Directed bench for window_read_sequencer (DATANUM=15, KSIZE=3): full sweeps, backpressure,
// stray start, clr abort and mid-sweep reset, checked against a sample-index model.
module tb_window_read_sequencer;

  localparam int DATANUM = 15;
  localparam int KSIZE   = 3;
  localparam int NWIN    = DATANUM - KSIZE + 1;

  logic                 clk;
  logic                 rstN;
  logic                 start;
  logic                 clr;
  logic                 rdReady;
  logic                 rdValid;
  logic [DATANUM-1:0]   rdSel;
  logic [3:0]           winIdx;
  logic [1:0]           tapIdx;
  logic                 lastTap;
  logic                 lastWin;
  logic                 busy;
  logic                 done;

  int checkCount = 0;
  int passCount  = 0;
  int hsCount    = 0;

  window_read_sequencer #(.DATANUM(DATANUM), .KSIZE(KSIZE)) dut (
    .i_clk      (clk),
    .i_rst_n    (rstN),
    .i_start    (start),
    .i_clr      (clr),
    .i_rd_ready (rdReady),
    .o_rd_valid (rdValid),
    .o_rd_sel   (rdSel),
    .o_win_idx  (winIdx),
    .o_tap_idx  (tapIdx),
    .o_last_tap (lastTap),
    .o_last_win (lastWin),
    .o_busy     (busy),
    .o_done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent handshake counter, sampled at the active edge.
  always @(posedge clk) begin
    if (rdValid && rdReady) hsCount = hsCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp)
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else
      passCount++;
  endtask

  function automatic logic [DATANUM-1:0] expSel(input int w, input int t);
    logic [DATANUM-1:0] v;
    v = '0;
    v[(w + t + DATANUM - 1) % DATANUM] = 1'b1;
    return v;
  endfunction

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_valid"}, 32'(rdValid), 32'd0);
    checkOutput({tag, "_sel"},   32'(rdSel),   32'd0);
    checkOutput({tag, "_win"},   32'(winIdx),  32'd0);
    checkOutput({tag, "_tap"},   32'(tapIdx),  32'd0);
    checkOutput({tag, "_ltap"},  32'(lastTap), 32'd0);
    checkOutput({tag, "_lwin"},  32'(lastWin), 32'd0);
    checkOutput({tag, "_busy"},  32'(busy),    32'd0);
    checkOutput({tag, "_done"},  32'(done),    32'd0);
  endtask

  task automatic checkSample(input int w, input int t);
    checkOutput("valid", 32'(rdValid), 32'd1);
    checkOutput("sel",   32'(rdSel),   32'(expSel(w, t)));
    checkOutput("win",   32'(winIdx),  32'(w));
    checkOutput("tap",   32'(tapIdx),  32'(t));
    checkOutput("ltap",  32'(lastTap), 32'(t == KSIZE - 1));
    checkOutput("lwin",  32'(lastWin), 32'(w == NWIN - 1));
    checkOutput("busy",  32'(busy),    32'd1);
  endtask

  // abortMode: 0 none, 1 clr (with simultaneous start), 2 reset (with start).
  task automatic applyStimulus(input int abortMode, input int abortW, input int abortT,
                               input int stallW, input int stallT,
                               input int strayW, input int strayT);
    int hsBase;
    hsBase  = hsCount;
    rdReady = 1'b1;
    start   = 1'b1;
    stepCycle();
    start = 1'b0;
    for (int w = 0; w < NWIN; w++) begin
      for (int t = 0; t < KSIZE; t++) begin
        checkSample(w, t);
        if (abortMode != 0 && w == abortW && t == abortT) begin
          start = 1'b1;
          if (abortMode == 1) clr = 1'b1;
          else rstN = 1'b0;
          stepCycle();
          checkIdle(abortMode == 1 ? "clr" : "rst");
          clr   = 1'b0;
          start = 1'b0;
          rstN  = 1'b1;
          for (int k = 0; k < 3; k++) begin
            stepCycle();
            checkOutput("abortValid", 32'(rdValid), 32'd0);
            checkOutput("abortBusy",  32'(busy),    32'd0);
            checkOutput("abortDone",  32'(done),    32'd0);
          end
          return;
        end
        if (w == stallW && t == stallT) begin
          rdReady = 1'b0;
          for (int k = 0; k < 5; k++) begin
            stepCycle();
            checkSample(w, t);
          end
          rdReady = 1'b1;
        end
        if (w == strayW && t == strayT) start = 1'b1;
        stepCycle();
        start = 1'b0;
      end
    end
    checkOutput("doneHs",    32'(hsCount - hsBase), 32'(NWIN * KSIZE));
    checkOutput("donePulse", 32'(done),    32'd1);
    checkOutput("doneValid", 32'(rdValid), 32'd0);
    checkOutput("doneSel",   32'(rdSel),   32'd0);
    checkOutput("doneBusy",  32'(busy),    32'd1);
    stepCycle();
    checkOutput("doneEnd",   32'(done),    32'd0);
    checkOutput("idleBusy",  32'(busy),    32'd0);
  endtask

  initial begin
    rstN    = 1'b0;
    start   = 1'b0;
    clr     = 1'b0;
    rdReady = 1'b0;
    stepCycle();
    start = 1'b1;
    stepCycle();
    checkIdle("reset");
    start = 1'b0;
    rstN  = 1'b1;
    stepCycle();
    checkIdle("postReset");

    $display("[TB] plain sweep");
    applyStimulus(0, -1, -1, -1, -1, -1, -1);
    $display("[TB] backpressure and stray start");
    applyStimulus(0, -1, -1, 4, 1, 3, 1);
    $display("[TB] replay sweep");
    applyStimulus(0, -1, -1, -1, -1, 7, 2);
    $display("[TB] clr abort");
    applyStimulus(1, 5, 1, -1, -1, -1, -1);
    $display("[TB] reset abort");
    applyStimulus(2, 2, 0, -1, -1, -1, -1);

    clr   = 1'b1;
    start = 1'b1;
    stepCycle();
    checkOutput("idleClrStart", 32'(busy), 32'd0);
    clr   = 1'b0;
    start = 1'b0;

    $display("[TB] final sweep");
    applyStimulus(0, -1, -1, 12, 2, -1, -1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
